// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with a registered read port, fill count, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module sync_fifo_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              flush,
  input  logic              err_clr,
  input  logic [ADDR_W:0]   af_thresh,
  input  logic [ADDR_W:0]   ae_thresh,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0] wptr_reg, rptr_reg;
  logic [ADDR_W:0] wptr_next, rptr_next;
  logic            we, re;
  logic            overflow_next, underflow_next;

  // The MSB of each pointer is a wrap bit, so equal low bits mean either
  // empty (same lap) or full (writer one lap ahead).
  assign count        = wptr_reg - rptr_reg;
  assign empty        = (wptr_reg == rptr_reg);
  assign full         = (wptr_reg[ADDR_W] != rptr_reg[ADDR_W]) &&
                        (wptr_reg[ADDR_W-1:0] == rptr_reg[ADDR_W-1:0]);
  assign almost_full  = (count >= af_thresh);
  assign almost_empty = (count <= ae_thresh);

  assign we = wr && !full  && !flush;
  assign re = rd && !empty && !flush;

  always_comb begin
    wptr_next      = wptr_reg;
    rptr_next      = rptr_reg;
    overflow_next  = overflow;
    underflow_next = underflow;

    if (flush) begin
      wptr_next = '0;
      rptr_next = '0;
    end else begin
      if (we) wptr_next = wptr_reg + PTR_ONE;
      if (re) rptr_next = rptr_reg + PTR_ONE;
    end

    // A set condition in the same cycle as err_clr keeps the flag high.
    if (err_clr) begin
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end
    if (wr && full && !flush)  overflow_next  = 1'b1;
    if (rd && empty && !flush) underflow_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (we) mem[wptr_reg[ADDR_W-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wptr_reg  <= wptr_next;
      rptr_reg  <= rptr_next;
      rd_valid  <= re;
      overflow  <= overflow_next;
      underflow <= underflow_next;
      if (re) rd_data <= mem[rptr_reg[ADDR_W-1:0]];
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed plus randomized bench for sync_fifo_param against a queue-based model.
module tb_sync_fifo_param;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr = 1'b0, rd = 1'b0, flush = 1'b0, err_clr = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [ADDR_W:0]   af_thresh = 7'd60, ae_thresh = 7'd4;
  logic [ADDR_W:0]   count;
  logic              full, empty, almost_full, almost_empty, overflow, underflow;

  sync_fifo_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .wr_data(wr_data), .rd(rd),
    .rd_data(rd_data), .rd_valid(rd_valid), .flush(flush), .err_clr(err_clr),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .count(count), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: contents as a queue, plus the registered outputs.
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_rd_data = '0;
  logic              m_rd_valid = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int step_no = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", tag, step_no, obs, exp);
    end
  endtask

  task automatic check_all();
    int n = q.size();
    check("count",        64'(count),        64'(n));
    check("full",         64'(full),         64'(n == DEPTH));
    check("empty",        64'(empty),        64'(n == 0));
    check("almost_full",  64'(almost_full),  64'(n >= int'(af_thresh)));
    check("almost_empty", 64'(almost_empty), 64'(n <= int'(ae_thresh)));
    check("overflow",     64'(overflow),     64'(m_ovf));
    check("underflow",    64'(underflow),    64'(m_unf));
    check("rd_valid",     64'(rd_valid),     64'(m_rd_valid));
    check("rd_data",      64'(rd_data),      64'(m_rd_data));
  endtask

  task automatic model_reset();
    q.delete();
    m_rd_data  = '0;
    m_rd_valid = 1'b0;
    m_ovf      = 1'b0;
    m_unf      = 1'b0;
  endtask

  // Called at posedge+1: apply inputs, clock once, advance model, compare.
  task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic r,
                      input logic f, input logic c);
    bit was_full, was_empty, nv, nu;
    wr = w; wr_data = d; rd = r; flush = f; err_clr = c;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    nv = c ? 1'b0 : m_ovf;
    nu = c ? 1'b0 : m_unf;
    if (w && was_full && !f)  nv = 1'b1;
    if (r && was_empty && !f) nu = 1'b1;
    m_ovf = nv;
    m_unf = nu;
    if (f) begin
      q.delete();
      m_rd_valid = 1'b0;
    end else begin
      m_rd_valid = r && !was_empty;
      if (m_rd_valid) m_rd_data = q.pop_front();
      if (w && !was_full) q.push_back(d);
    end
    #1;
    step_no++;
    $display("step %0d wr=%0b d=%0h rd=%0b fl=%0b clr=%0b -> cnt=%0d rv=%0b rdata=%0h",
             step_no, w, d, r, f, c, count, rd_valid, rd_data);
    check_all();
  endtask

  initial begin
    // Reset state
    #12;
    check_all();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: fill to full, then a dropped write
    for (int i = 0; i < DEPTH; i++) step(1, DATA_W'(i), 0, 0, 0);
    step(1, 32'hDEAD, 0, 0, 0);

    // 2: drain in order, then an extra read
    for (int i = 0; i < DEPTH; i++) step(0, '0, 1, 0, 0);
    step(0, '0, 1, 0, 0);

    // 3: steady state at count 10 across several pointer wraps
    step(0, '0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 32'h1000 + DATA_W'(i), 0, 0, 0);
    for (int i = 0; i < 200; i++) step(1, 32'h2000 + DATA_W'(i), 1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, '0, 1, 0, 0);
    step(0, '0, 1, 0, 1);

    // 4: flush with wr and rd at count 20
    for (int i = 0; i < 20; i++) step(1, 32'h3000 + DATA_W'(i), 0, 0, 0);
    step(1, 32'hBAD0, 1, 1, 0);
    step(1, 32'h4000, 0, 0, 0);
    step(0, '0, 1, 0, 0);

    // 5: threshold boundaries
    ae_thresh = 7'd4; af_thresh = 7'd8;
    for (int i = 0; i < 9; i++) step(1, 32'h5000 + DATA_W'(i), 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, '0, 1, 0, 0);

    // 6: asynchronous reset mid-burst at count 33
    for (int i = 0; i < 33; i++) step(1, 32'h6000 + DATA_W'(i), 0, 0, 0);
    wr = 1'b1; rd = 1'b1; wr_data = 32'h6FFF;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    wr = 1'b0; rd = 1'b0;
    #1 rst_n = 1'b1;
    step(1, 32'h7777, 0, 0, 0);
    step(0, '0, 1, 0, 0);

    // Randomized traffic with phase-dependent bias and live thresholds
    for (int i = 0; i < 1500; i++) begin
      int pw, pr;
      case ((i / 100) % 3)
        0: begin pw = 80; pr = 30; end
        1: begin pw = 30; pr = 80; end
        default: begin pw = 60; pr = 60; end
      endcase
      if (i % 100 == 0) begin
        af_thresh = 7'($urandom_range(0, 70));
        ae_thresh = 7'($urandom_range(0, 70));
      end
      step($urandom_range(0, 99) < pw, $urandom, $urandom_range(0, 99) < pr,
           $urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
